// File: rtl/fetch_stage.sv
// fetch_stage: PC register and IF/ID pipeline register with ID-resolved redirects and squash
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        is_jump,
  input  logic [1:0]  mux_pc,
  input  logic [31:0] rs_data,
  input  logic [31:0] instr_imem,
  output logic [31:0] pc_if,
  output logic [31:0] instr_id,
  output logic [31:0] pc4_id,
  output logic        valid_id,
  output logic [31:0] fetch_count
);
  logic [31:0] pc_next_seq;
  logic [31:0] br_target;
  logic [31:0] target;
  logic        redirect;
  always_comb begin
    pc_next_seq = pc_if + 32'd4;
    br_target   = pc4_id + {{14{instr_id[15]}}, instr_id[15:0], 2'b00};
    target      = mux_pc == 2'b00 ? {pc4_id[31:28], instr_id[25:0], 2'b00} :
                  mux_pc == 2'b01 ? rs_data : br_target;
    redirect    = is_jump & valid_id & ~stall & (mux_pc != 2'b10);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_if       <= RESET_PC;
      instr_id    <= '0;
      pc4_id      <= '0;
      valid_id    <= 1'b0;
      fetch_count <= '0;
    end else if (!stall) begin
      if (redirect) begin
        // the wrong-path fetch behind a taken redirect becomes a NOP bubble
        pc_if    <= target;
        instr_id <= '0;
        pc4_id   <= '0;
        valid_id <= 1'b0;
      end else begin
        pc_if       <= pc_next_seq;
        instr_id    <= instr_imem;
        pc4_id      <= pc_next_seq;
        valid_id    <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors against a cycle-level model of the fetch stage
module tb_fetch_stage;
  logic        clk = 0;
  logic        rst, stall, is_jump;
  logic [1:0]  mux_pc;
  logic [31:0] rs_data, instr_imem, pc_if, instr_id, pc4_id, fetch_count;
  logic        valid_id;
  int checks = 0, failures = 0;
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;
  fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .is_jump(is_jump), .mux_pc(mux_pc),
    .rs_data(rs_data), .instr_imem(instr_imem), .pc_if(pc_if), .instr_id(instr_id),
    .pc4_id(pc4_id), .valid_id(valid_id), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0040_0004) return 32'h0810_0040;
    if (a == 32'h0040_000C) return 32'h1000_FFFF;
    return {16'h2400, a[15:0]};
  endfunction
  assign instr_imem = rom(pc_if);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: next state straight from the rules, arithmetic on whole values
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'h0040_0000; m_instr <= 0; m_pc4 <= 0; m_valid <= 0; m_cnt <= 0;
    end else if (!stall) begin
      if (is_jump && m_valid && mux_pc != 2'b10) begin
        m_pc <= mux_pc == 2'b00 ? {m_pc4[31:28], m_instr[25:0], 2'b00} :
                mux_pc == 2'b01 ? rs_data :
                m_pc4 + 32'(4 * int'($signed(m_instr[15:0])));
        m_instr <= 0; m_pc4 <= 0; m_valid <= 0;
      end else begin
        m_pc <= m_pc + 4; m_instr <= rom(m_pc); m_pc4 <= m_pc + 4; m_valid <= 1; m_cnt <= m_cnt + 1;
      end
    end
  end
  always @(negedge clk) begin
    chk("cyc_pc_if", pc_if, m_pc);
    chk("cyc_instr_id", instr_id, m_instr);
    chk("cyc_pc4_id", pc4_id, m_pc4);
    chk("cyc_valid_id", {31'b0, valid_id}, {31'b0, m_valid});
    chk("cyc_fetch_count", fetch_count, m_cnt);
  end
  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask
  initial begin
    rst = 0; stall = 0; is_jump = 0; mux_pc = 0; rs_data = 0;
    #1 rst = 1;
    @(posedge clk); #2 rst = 0;
    #1;
    chk("rst_pc", pc_if, 32'h0040_0000);
    chk("rst_valid", {31'b0, valid_id}, 0);
    chk("rst_cnt", fetch_count, 0);
    go(1); chk("run_pc1", pc_if, 32'h0040_0004);
    chk("run_instr1", instr_id, 32'h2400_0000);
    go(1); chk("run_pc2", pc_if, 32'h0040_0008);
    chk("run_cnt2", fetch_count, 2);
    chk("j_instr", instr_id, 32'h0810_0040);
    chk("j_pc4", pc4_id, 32'h0040_0008);
    is_jump = 1; mux_pc = 2'b00;
    go(1); chk("j_target", pc_if, 32'h0040_0100);
    chk("j_squash_valid", {31'b0, valid_id}, 0);
    chk("j_squash_instr", instr_id, 0);
    chk("j_cnt_hold", fetch_count, 2);
    is_jump = 0;
    go(2); chk("j_after", pc_if, 32'h0040_0108);
    is_jump = 1; mux_pc = 2'b01; rs_data = 32'h0040_0200;
    go(1); chk("jr_target", pc_if, 32'h0040_0200);
    is_jump = 0;
    go(1); chk("jr_after_valid", {31'b0, valid_id}, 1);
    is_jump = 1; rs_data = 32'h0040_000C;
    go(1); is_jump = 0;
    go(1); chk("beq_instr", instr_id, 32'h1000_FFFF);
    chk("beq_pc4", pc4_id, 32'h0040_0010);
    is_jump = 1; mux_pc = 2'b11;
    go(1); chk("beq_target", pc_if, 32'h0040_000C);
    chk("beq_squash_valid", {31'b0, valid_id}, 0);
    chk("beq_squash_instr", instr_id, 0);
    is_jump = 0;
    go(1); chk("beq_refetch", instr_id, 32'h1000_FFFF);
    chk("beq_cnt", fetch_count, 7);
    stall = 1; is_jump = 1; mux_pc = 2'b11;
    go(1); chk("stall1_pc", pc_if, 32'h0040_0010);
    go(1); chk("stall2_pc", pc_if, 32'h0040_0010);
    chk("stall2_instr", instr_id, 32'h1000_FFFF);
    chk("stall2_cnt", fetch_count, 7);
    stall = 0;
    go(1); chk("post_stall_pc", pc_if, 32'h0040_000C);
    chk("post_stall_valid", {31'b0, valid_id}, 0);
    go(1); chk("once_pc", pc_if, 32'h0040_0010);
    chk("once_valid", {31'b0, valid_id}, 1);
    chk("once_cnt", fetch_count, 8);
    mux_pc = 2'b10;
    go(1); chk("illegal_pc", pc_if, 32'h0040_0014);
    chk("illegal_valid", {31'b0, valid_id}, 1);
    chk("illegal_cnt", fetch_count, 9);
    mux_pc = 2'b01; rs_data = 32'hFFFF_FFFC;
    go(1); chk("wrap_jr", pc_if, 32'hFFFF_FFFC);
    is_jump = 0;
    go(1); chk("wrap_pc", pc_if, 0);
    chk("wrap_pc4", pc4_id, 0);
    chk("wrap_valid", {31'b0, valid_id}, 1);
    chk("wrap_cnt", fetch_count, 10);
    go(1); chk("wrap_next", pc_if, 32'h0000_0004);
    stall = 1;
    go(1); #1 rst = 1;
    #1;
    chk("arst_pc", pc_if, 32'h0040_0000);
    chk("arst_instr", instr_id, 0);
    chk("arst_pc4", pc4_id, 0);
    chk("arst_valid", {31'b0, valid_id}, 0);
    chk("arst_cnt", fetch_count, 0);
    @(posedge clk); #2 rst = 0; stall = 0;
    #1 chk("resume_pc0", pc_if, 32'h0040_0000);
    go(1); chk("resume_pc1", pc_if, 32'h0040_0004);
    chk("resume_cnt", fetch_count, 1);
    go(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It holds the PC, presents the fetch address to instruction memory, and registers the fetched word into the IF/ID pipeline register. It feeds the decode-stage controller and consumes that controller's redirect outputs (`is_jump`, `mux_pc`) to compute the next PC. Branches and jumps are resolved in ID. There is no architectural delay slot: the instruction fetched behind a taken redirect is squashed.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC value loaded on reset.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `stall`  in  1: hazard-unit hold request (load-use or multi-cycle mul); freezes PC and IF/ID.
- `is_jump`  in  1: redirect request from the decode controller for the instruction currently in ID.
- `mux_pc`  in  2: redirect source. 00 = J/JAL target, 01 = JR register, 11 = branch target, 10 = illegal.
- `rs_data`  in  32: forwarded rs value in ID; used as the JR target.
- `instr_imem`  in  32: combinational instruction-memory read data at `pc_if`.
- `pc_if`  out  32: current fetch address to instruction memory.
- `instr_id`  out  32: IF/ID instruction register.
- `pc4_id`  out  32: IF/ID register holding fetch PC + 4; used for the JAL link value and the branch base.
- `valid_id`  out  1: IF/ID holds a real, non-squashed instruction.
- `fetch_count`  out  32: count of instructions accepted into IF/ID (debug).

## Operation
- Sequential next PC: `pc_if + 4`, computed mod 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Redirect targets, all computed from IF/ID contents:
  - J/JAL (00): `{pc4_id[31:28], instr_id[25:0], 2'b00}`.
  - JR (01): `rs_data`.
  - Branch (11): `pc4_id + (sign_ext(instr_id[15:0]) << 2)`, mod 2^32.
- A redirect is taken when `is_jump & valid_id & ~stall` and `mux_pc != 10`.
- `is_jump` with `mux_pc == 10` is treated as no redirect: sequential fetch, no squash.
- Priority per cycle, highest first:
  1. `rst`: PC = `RESET_PC`; IF/ID cleared.
  2. `stall`: PC, `instr_id`, `pc4_id`, `valid_id`, and `fetch_count` all hold. A pending `is_jump` is not acted on; it is re-evaluated once the stall drops.
  3. Redirect: PC = target. IF/ID loads NOP (`instr_id` = 0, `valid_id` = 0, `pc4_id` = 0). `fetch_count` holds.
  4. Normal: PC = `pc_if + 4`. IF/ID loads `instr_imem`, `pc4_id` = `pc_if + 4`, `valid_id` = 1. `fetch_count` increments.
- `fetch_count` wraps from 0xFFFF_FFFF to 0.
- When `valid_id` = 0, the ID instruction is a NOP (sll $0,$0,0). Its `is_jump` is ignored by the valid qualifier above.

## Timing
- Reset values: `pc_if` = `RESET_PC`, `instr_id` = 0, `pc4_id` = 0, `valid_id` = 0, `fetch_count` = 0.
- Reset asserts immediately (asynchronously). The first fetch uses `RESET_PC` in the first cycle after `rst` deasserts. `instr_imem` at `RESET_PC` appears in `instr_id` one edge later.
- Reset asserted mid-operation aborts any redirect or stall state. No state survives reset.
- IF→ID latency: 1 cycle.
- Taken-redirect penalty: exactly 1 squashed slot. The target is fetched on the edge after the redirect cycle and appears in ID one edge after that.
- A stall lasting N cycles adds exactly N cycles. No instruction is lost or duplicated.
- Outputs are registered, except that `pc_if` is the PC register itself. There is no combinational path from `is_jump` or `stall` to any output.

## Test plan
- Reset with `RESET_PC` = 0x0040_0000, then free-run 3 cycles with no stall or jump -> `pc_if` = 0x0040_0000, 0x0040_0004, 0x0040_0008; `instr_id` follows one cycle behind; `fetch_count` = 2 after the 3rd edge.
- `instr_id` = BEQ with imm 0xFFFF, `pc4_id` = 0x0040_0010, `is_jump` = 1, `mux_pc` = 11 -> `pc_if` = 0x0040_000C next cycle; that cycle shows `valid_id` = 0 and `instr_id` = 0.
- `instr_id` = J with field 0x010_0040, `pc4_id` = 0x0040_0008, `mux_pc` = 00, `is_jump` = 1 -> `pc_if` = 0x0040_0100. Repeat with JR, `rs_data` = 0x0040_0200 -> `pc_if` = 0x0040_0200.
- `stall` high for 2 cycles while `is_jump` = 1 -> `pc_if`, `instr_id`, and `fetch_count` are unchanged for both cycles. On the cycle after `stall` drops, the redirect is taken once.
- `pc_if` = 0xFFFF_FFFC, normal fetch -> `pc_if` = 0, `pc4_id` = 0, `valid_id` = 1. Separately, `is_jump` = 1 with `mux_pc` = 10 -> sequential fetch with no squash.
- Assert `rst` asynchronously mid-cycle during a stall -> all outputs take reset values before the next edge. Fetch resumes at `RESET_PC`.
